kbd_intc_arbiter: RTL and testbench

- Interrupt controller that shares the single CPU interrupt line among NUM_SRC peripheral sources, e.g. the keyboard controller and the serial/timer blocks.
- Each source uses a level IRQ / one-cycle IACK / one-cycle IEND handshake.
- Selects one requester, presents its vector to the CPU, and relays the CPU's acknowledge and end-of-interrupt back to that source.
- Only one interrupt is in service at a time; no nesting.

---
 rtl/kbd_intc_arbiter_if.sv | 37 +++
 rtl/kbd_intc_arbiter.sv | 132 +++++++++++++
 tb/tb_kbd_intc_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_intc_arbiter_if.sv
// kbd_intc_arbiter_if: groups the source-side and CPU-side interrupt signals.
//   master modport : arbiter view (drives IACK/IEND/CPU_IRQ/CPU_VECTOR/BUSY)
//   slave modport  : peripheral/CPU view (drives IRQ/MASK/ACK/EOI)
// Signals:
//   SRC_IRQ    level request per source, held until its IACK
//   SRC_MASK   1 = source not eligible for selection
//   SRC_IACK   one-cycle acknowledge pulse to the selected source
//   SRC_IEND   one-cycle end-of-service pulse to the selected source
//   CPU_IRQ    interrupt request to the CPU
//   CPU_VECTOR index of the source offered or in service
//   CPU_ACK    CPU accepts the offered interrupt
//   CPU_EOI    CPU finished the handler
//   BUSY       arbiter is not idle
interface kbd_intc_arbiter_if #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned VEC_W   = 2
);
   logic [NUM_SRC-1:0] SRC_IRQ;
   logic [NUM_SRC-1:0] SRC_MASK;
   logic [NUM_SRC-1:0] SRC_IACK;
   logic [NUM_SRC-1:0] SRC_IEND;
   logic               CPU_IRQ;
   logic [VEC_W-1:0]   CPU_VECTOR;
   logic               CPU_ACK;
   logic               CPU_EOI;
   logic               BUSY;

   modport master (
      input  SRC_IRQ, SRC_MASK, CPU_ACK, CPU_EOI,
      output SRC_IACK, SRC_IEND, CPU_IRQ, CPU_VECTOR, BUSY
   );

   modport slave (
      output SRC_IRQ, SRC_MASK, CPU_ACK, CPU_EOI,
      input  SRC_IACK, SRC_IEND, CPU_IRQ, CPU_VECTOR, BUSY
   );
endinterface

// File: rtl/kbd_intc_arbiter.sv
// kbd_intc_arbiter: shares one CPU interrupt line among NUM_SRC sources.
// One interrupt in service at a time: IDLE -> PEND -> ACK -> SERVICE -> END.
// Ports:
//   CLK      system clock, rising edge
//   RESET_N  synchronous active-low reset
//   bus      kbd_intc_arbiter_if.master (source and CPU handshake signals)
// Build option:
//   INTC_ROUND_ROBIN_EN  round-robin selection from a rotating priority pointer;
//                        undefined gives fixed lowest-index priority.
module kbd_intc_arbiter #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned VEC_W   = 2
) (
   input logic                  CLK,
   input logic                  RESET_N,
   kbd_intc_arbiter_if.master   bus
);

   typedef enum logic [2:0] {StIdle, StPend, StAck, StService, StEnd} state_e;

   localparam logic [NUM_SRC-1:0] SrcOne = NUM_SRC'(1);

   state_e             state_q;
   logic [VEC_W-1:0]   vec_q;
   logic               irq_q;
   logic               busy_q;
   logic [NUM_SRC-1:0] iack_q;
   logic [NUM_SRC-1:0] iend_q;

   logic [NUM_SRC-1:0] elig;
   logic [NUM_SRC-1:0] vec_oh;
   logic [VEC_W-1:0]   win;

   assign elig   = bus.SRC_IRQ & ~bus.SRC_MASK;
   assign vec_oh = SrcOne << vec_q;

`ifdef INTC_ROUND_ROBIN_EN
   logic [VEC_W-1:0] ptr_q;
   logic [VEC_W:0]   sum;

   // Scan offsets downward so the smallest offset from the pointer wins.
   always_comb begin
      win = '0;
      sum = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         sum = {1'b0, ptr_q} + (VEC_W + 1)'(k);
         if (sum >= (VEC_W + 1)'(NUM_SRC)) begin
            sum = sum - (VEC_W + 1)'(NUM_SRC);
         end
         if (|(elig & (SrcOne << sum[VEC_W-1:0]))) begin
            win = sum[VEC_W-1:0];
         end
      end
   end
`else
   always_comb begin
      win = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (elig[i]) begin
            win = VEC_W'(i);
         end
      end
   end
`endif

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q <= StIdle;
         vec_q   <= '0;
         irq_q   <= 1'b0;
         busy_q  <= 1'b0;
         iack_q  <= '0;
         iend_q  <= '0;
`ifdef INTC_ROUND_ROBIN_EN
         ptr_q   <= '0;
`endif
      end else begin
         iack_q <= '0;
         iend_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (|elig) begin
                  vec_q   <= win;
                  irq_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= StPend;
               end
            end
            StPend: begin
               // Acceptance wins over a withdrawal in the same cycle.
               if (bus.CPU_ACK) begin
                  irq_q   <= 1'b0;
                  iack_q  <= vec_oh;
                  state_q <= StAck;
               end else if (!(|(elig & vec_oh))) begin
                  irq_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            StAck: begin
               state_q <= StService;
            end
            StService: begin
               if (bus.CPU_EOI) begin
                  iend_q  <= vec_oh;
                  state_q <= StEnd;
`ifdef INTC_ROUND_ROBIN_EN
                  ptr_q   <= (vec_q == VEC_W'(NUM_SRC - 1)) ? '0 : vec_q + 1'b1;
`endif
               end
            end
            StEnd: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               irq_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.CPU_IRQ    = irq_q;
   assign bus.CPU_VECTOR = vec_q;
   assign bus.BUSY       = busy_q;
   assign bus.SRC_IACK   = iack_q;
   assign bus.SRC_IEND   = iend_q;

endmodule

// File: tb/tb_kbd_intc_arbiter.sv
// Scoreboard bench for kbd_intc_arbiter: stimulus pushes expected offer/IACK/IEND
// events; a negedge monitor pops and compares each event the DUT presents.
module tb_kbd_intc_arbiter;

   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned VEC_W   = 2;

   localparam int KOffer = 0;
   localparam int KIack  = 1;
   localparam int KIend  = 2;

   typedef struct {
      int       kind;
      logic [3:0] data;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;
   bit   mon_en;
   logic prev_irq;
   exp_t sbq[$];

   kbd_intc_arbiter_if #(.NUM_SRC(NUM_SRC), .VEC_W(VEC_W)) bus ();

   kbd_intc_arbiter #(.NUM_SRC(NUM_SRC), .VEC_W(VEC_W)) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic string kname(input int k);
      if (k == KOffer) return "offer";
      if (k == KIack)  return "iack";
      return "iend";
   endfunction

   task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int kind, input logic [3:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      sbq.push_back(e);
   endtask

   task automatic check_event(input int kind, input logic [3:0] data);
      exp_t e;
      n_vec++;
      if (sbq.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_%s: got %0h, expected no event (t=%0t)", kname(kind), data,
                  $time);
      end else begin
         e = sbq.pop_front();
         if (e.kind != kind || e.data !== data) begin
            n_bad++;
            $display("FAIL event: got %s %0h, expected %s %0h (t=%0t)", kname(kind), data,
                     kname(e.kind), e.data, $time);
         end
      end
   endtask

   // Monitor: pops the scoreboard on every offer edge and IACK/IEND pulse.
   initial begin
      prev_irq = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            n_vec++;
            if (!$onehot0(bus.SRC_IACK) || !$onehot0(bus.SRC_IEND) ||
                ((|bus.SRC_IACK) && (|bus.SRC_IEND)) || (bus.CPU_VECTOR >= NUM_SRC)) begin
               n_bad++;
               $display("FAIL pulse_rules: iack %0h iend %0h vec %0h (t=%0t)", bus.SRC_IACK,
                        bus.SRC_IEND, bus.CPU_VECTOR, $time);
            end
            if (bus.CPU_IRQ && !prev_irq) check_event(KOffer, 4'(bus.CPU_VECTOR));
            if (|bus.SRC_IACK) check_event(KIack, bus.SRC_IACK);
            if (|bus.SRC_IEND) check_event(KIend, bus.SRC_IEND);
            prev_irq = bus.CPU_IRQ;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      bus.SRC_IRQ  = '0;
      bus.SRC_MASK = '0;
      bus.CPU_ACK  = 1'b0;
      bus.CPU_EOI  = 1'b0;
      step();
      mon_en = 1'b1;
      expect_eq("rst_cpu_irq", 32'(bus.CPU_IRQ), 0);
      expect_eq("rst_vector", 32'(bus.CPU_VECTOR), 0);
      expect_eq("rst_iack", 32'(bus.SRC_IACK), 0);
      expect_eq("rst_iend", 32'(bus.SRC_IEND), 0);
      expect_eq("rst_busy", 32'(bus.BUSY), 0);
      rst_n = 1'b1;
      step();
      expect_eq("idle_busy", 32'(bus.BUSY), 0);
   endtask

   // Raise requests from IDLE and expect the offer one cycle later.
   task automatic offer(input logic [3:0] irq, input int exp_vec);
      bus.SRC_IRQ = irq;
      push(KOffer, 4'(exp_vec));
      step();
      expect_eq("offer_irq", 32'(bus.CPU_IRQ), 1);
      expect_eq("offer_vec", 32'(bus.CPU_VECTOR), 32'(exp_vec));
      expect_eq("offer_busy", 32'(bus.BUSY), 1);
   endtask

   // From PEND: CPU accepts; ends with the DUT in SERVICE.
   task automatic do_ack(input logic [3:0] oh, input bit drop);
      bus.CPU_ACK = 1'b1;
      push(KIack, oh);
      step();
      expect_eq("ack_iack", 32'(bus.SRC_IACK), 32'(oh));
      expect_eq("ack_cpu_irq", 32'(bus.CPU_IRQ), 0);
      bus.CPU_ACK = 1'b0;
      if (drop) bus.SRC_IRQ = bus.SRC_IRQ & ~oh;
      bus.CPU_EOI = 1'b1;  // EOI in ACK must be ignored
      step();
      expect_eq("svc_iack", 32'(bus.SRC_IACK), 0);
      expect_eq("svc_iend", 32'(bus.SRC_IEND), 0);
      expect_eq("svc_busy", 32'(bus.BUSY), 1);
      bus.CPU_EOI = 1'b0;
   endtask

   // From SERVICE: mask changes ignored, then EOI; ends in IDLE.
   task automatic do_service(input logic [3:0] oh);
      bus.SRC_MASK = '1;
      step();
      expect_eq("svc_hold_iend", 32'(bus.SRC_IEND), 0);
      expect_eq("svc_hold_busy", 32'(bus.BUSY), 1);
      bus.SRC_MASK = '0;
      bus.CPU_EOI  = 1'b1;
      push(KIend, oh);
      step();
      expect_eq("end_iend", 32'(bus.SRC_IEND), 32'(oh));
      bus.CPU_EOI = 1'b0;
      step();
      expect_eq("idle_iend", 32'(bus.SRC_IEND), 0);
      expect_eq("idle_busy", 32'(bus.BUSY), 0);
      expect_eq("idle_cpu_irq", 32'(bus.CPU_IRQ), 0);
   endtask

   initial begin
      int seq[4];
`ifdef INTC_ROUND_ROBIN_EN
      seq = '{0, 1, 0, 1};
`else
      seq = '{0, 0, 0, 0};
`endif
      n_vec  = 0;
      n_bad  = 0;
      mon_en = 1'b0;
      rst_n  = 1'b0;

      // Single source, full handshake.
      do_reset();
      offer(4'b0010, 1);
      do_ack(4'b0010, 1'b1);
      do_service(4'b0010);
      expect_eq("vec_held_idle", 32'(bus.CPU_VECTOR), 1);

      // Two simultaneous requests: 1 then 3.
      do_reset();
      offer(4'b1010, 1);
      do_ack(4'b0010, 1'b1);
      do_service(4'b0010);
      offer(4'b1000, 3);
      do_ack(4'b1000, 1'b1);
      do_service(4'b1000);

      // Two sources held continuously.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         offer(4'b0011, seq[i]);
         do_ack(4'(1 << seq[i]), 1'b0);
         do_service(4'(1 << seq[i]));
      end
      bus.SRC_IRQ = '0;

      // No preemption in PEND, then withdrawal by masking.
      do_reset();
      offer(4'b0100, 2);
      bus.SRC_IRQ = 4'b0101;
      step();
      expect_eq("no_preempt_vec", 32'(bus.CPU_VECTOR), 2);
      expect_eq("no_preempt_irq", 32'(bus.CPU_IRQ), 1);
      bus.SRC_IRQ  = 4'b0100;
      bus.SRC_MASK = 4'b0100;
      step();
      expect_eq("withdraw_irq", 32'(bus.CPU_IRQ), 0);
      expect_eq("withdraw_busy", 32'(bus.BUSY), 0);
      bus.CPU_ACK = 1'b1;  // ACK outside PEND
      step();
      expect_eq("stray_ack_busy", 32'(bus.BUSY), 0);
      expect_eq("stray_ack_iack", 32'(bus.SRC_IACK), 0);
      bus.CPU_ACK  = 1'b0;
      bus.SRC_IRQ  = '0;
      bus.SRC_MASK = '0;

      // Request drop and CPU_ACK in the same cycle.
      do_reset();
      offer(4'b0001, 0);
      bus.SRC_IRQ = '0;
      do_ack(4'b0001, 1'b0);
      do_service(4'b0001);

      // Reset during SERVICE, then normal service.
      do_reset();
      offer(4'b0100, 2);
      do_ack(4'b0100, 1'b1);
      do_reset();
      expect_eq("post_rst_iend", 32'(bus.SRC_IEND), 0);
      offer(4'b0001, 0);
      do_ack(4'b0001, 1'b1);
      do_service(4'b0001);

      step();
      expect_eq("scoreboard_empty", 32'(sbq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
